pixel_reorder_buffer: RTL and testbench

Multi-engine reorder buffer between the pixel-calculation engines and the combinator. Accepts completed pixels (x, y, colour) from NUM_ENGINES independent engines in any order. Emits them as a strict raster-order stream over a valid/ready handshake. Replaces the single-channel shift queue with a windowed circular buffer, round-robin arbitration, backpressure, frame wrap and error reporting.

---
 rtl/pixel_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/pixel_reorder_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_pixel_reorder_buffer.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel types and helpers for the reorder path.
// Default widths and raster index arithmetic.
package pixel_pkg;

  localparam int PIX_COORD_W  = 11;
  localparam int PIX_COLOUR_W = 24;

  typedef struct packed {
    logic [PIX_COORD_W-1:0]  x;
    logic [PIX_COORD_W-1:0]  y;
    logic [PIX_COLOUR_W-1:0] colour;
  } pixel_t;

  function automatic logic [31:0] lin_idx(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] w
  );
    return y * w + x;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, one-hot grant per cycle.
// Priority moves to the requester after the last one granted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // First requester at or after the priority pointer wins.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (req[idx] && !found) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = PW'((int'(idx) + 1) % N);
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pixel_reorder_buffer.sv
// Reorder buffer: gathers pixels from several engines in any order
// and releases them as a raster-ordered valid/ready stream.
module pixel_reorder_buffer
  import pixel_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int COORD_W     = PIX_COORD_W,
  parameter int COLOUR_W    = PIX_COLOUR_W,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int DEPTH       = 16,
  localparam int IDX_W      = $clog2(IMG_W * IMG_H)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_ENGINES-1:0]          in_valid,
  output logic [NUM_ENGINES-1:0]          in_ready,
  input  logic [NUM_ENGINES*COORD_W-1:0]  in_x,
  input  logic [NUM_ENGINES*COORD_W-1:0]  in_y,
  input  logic [NUM_ENGINES*COLOUR_W-1:0] in_colour,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COORD_W-1:0]              out_x,
  output logic [COORD_W-1:0]              out_y,
  output logic [COLOUR_W-1:0]             out_colour,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy,
  output logic                            err_dup,
  output logic                            err_range
);

  localparam int FRAME = IMG_W * IMG_H;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int EW    = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

  logic [DEPTH-1:0]    slot_v_q, slot_v_d;
  logic [COLOUR_W-1:0] slot_c_q [DEPTH];
  logic [COLOUR_W-1:0] slot_c_d [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [COORD_W-1:0]  exp_x_q, exp_x_d;
  logic [COORD_W-1:0]  exp_y_q, exp_y_d;
  logic [IDX_W-1:0]    exp_idx_q, exp_idx_d;
  logic                out_valid_q, out_valid_d;
  logic [COORD_W-1:0]  out_x_q, out_x_d;
  logic [COORD_W-1:0]  out_y_q, out_y_d;
  logic [COLOUR_W-1:0] out_colour_q, out_colour_d;
  logic                out_sof_q, out_sof_d;
  logic                out_eol_q, out_eol_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic                err_dup_q, err_dup_d;
  logic                err_range_q, err_range_d;

  logic [COORD_W-1:0]   e_x    [NUM_ENGINES];
  logic [COORD_W-1:0]   e_y    [NUM_ENGINES];
  logic [COLOUR_W-1:0]  e_c    [NUM_ENGINES];
  logic [31:0]          e_off  [NUM_ENGINES];
  logic [PTR_W-1:0]     e_slot [NUM_ENGINES];
  logic [NUM_ENGINES-1:0] e_bad, e_win, e_dup, req, gnt;
  logic [EW-1:0]        g_idx;
  logic                 acc, wr, pop;

  // Classify each engine's offer against the current raster window.
  always_comb begin
    logic [31:0] l;
    l = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      e_x[i] = in_x[i*COORD_W +: COORD_W];
      e_y[i] = in_y[i*COORD_W +: COORD_W];
      e_c[i] = in_colour[i*COLOUR_W +: COLOUR_W];
      l = lin_idx(32'(e_x[i]), 32'(e_y[i]), 32'(IMG_W));
      if (l >= 32'(exp_idx_q))
        e_off[i] = l - 32'(exp_idx_q);
      else
        e_off[i] = l + 32'(FRAME) - 32'(exp_idx_q);
      e_slot[i] = rd_ptr_q + e_off[i][PTR_W-1:0];
      e_bad[i]  = (32'(e_x[i]) >= 32'(IMG_W)) ||
                  (32'(e_y[i]) >= 32'(IMG_H));
      e_win[i]  = !e_bad[i] && (e_off[i] < 32'(DEPTH));
      e_dup[i]  = e_win[i] && slot_v_q[e_slot[i]];
      req[i]    = !reset && in_valid[i] && (e_bad[i] || e_win[i]);
    end
  end

  rr_arbiter #(
    .N(NUM_ENGINES)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .gnt  (gnt)
  );

  assign in_ready = gnt;

  // Encode the one-hot grant.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_ENGINES; i++)
      if (gnt[i]) g_idx = EW'(i);
  end

  // Slot write, head pop, raster advance and output staging.
  always_comb begin
    acc = |gnt;
    wr  = acc && e_win[g_idx] && !e_dup[g_idx];
    pop = slot_v_q[rd_ptr_q] && (!out_valid_q || out_ready);

    slot_v_d     = slot_v_q;
    slot_c_d     = slot_c_q;
    rd_ptr_d     = rd_ptr_q;
    exp_x_d      = exp_x_q;
    exp_y_d      = exp_y_q;
    exp_idx_d    = exp_idx_q;
    out_valid_d  = out_valid_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_colour_d = out_colour_q;
    out_sof_d    = out_sof_q;
    out_eol_d    = out_eol_q;
    err_dup_d    = acc && e_dup[g_idx];
    err_range_d  = acc && e_bad[g_idx];
    occ_d        = occ_q + OCC_W'(wr) - OCC_W'(pop);

    if (wr) begin
      slot_v_d[e_slot[g_idx]] = 1'b1;
      slot_c_d[e_slot[g_idx]] = e_c[g_idx];
    end

    if (pop) begin
      out_valid_d        = 1'b1;
      out_x_d            = exp_x_q;
      out_y_d            = exp_y_q;
      out_colour_d       = slot_c_q[rd_ptr_q];
      out_sof_d          = (exp_idx_q == '0);
      out_eol_d          = (exp_x_q == X_LAST);
      slot_v_d[rd_ptr_q] = 1'b0;
      rd_ptr_d           = rd_ptr_q + PTR_W'(1);
      if (exp_x_q == X_LAST) begin
        exp_x_d = '0;
        if (exp_y_q == Y_LAST) begin
          exp_y_d   = '0;
          exp_idx_d = '0;
        end else begin
          exp_y_d   = exp_y_q + COORD_W'(1);
          exp_idx_d = exp_idx_q + IDX_W'(1);
        end
      end else begin
        exp_x_d   = exp_x_q + COORD_W'(1);
        exp_idx_d = exp_idx_q + IDX_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output state.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_v_q     <= '0;
      rd_ptr_q     <= '0;
      exp_x_q      <= '0;
      exp_y_q      <= '0;
      exp_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_colour_q <= '0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      occ_q        <= '0;
      err_dup_q    <= 1'b0;
      err_range_q  <= 1'b0;
    end else begin
      slot_v_q     <= slot_v_d;
      rd_ptr_q     <= rd_ptr_d;
      exp_x_q      <= exp_x_d;
      exp_y_q      <= exp_y_d;
      exp_idx_q    <= exp_idx_d;
      out_valid_q  <= out_valid_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_colour_q <= out_colour_d;
      out_sof_q    <= out_sof_d;
      out_eol_q    <= out_eol_d;
      occ_q        <= occ_d;
      err_dup_q    <= err_dup_d;
      err_range_q  <= err_range_d;
    end
  end

  // Slot colour storage; validity is tracked separately.
  always_ff @(posedge clk) begin
    slot_c_q <= slot_c_d;
  end

  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_colour = out_colour_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign occupancy  = occ_q;
  assign err_dup    = err_dup_q;
  assign err_range  = err_range_q;

endmodule

// File: tb/tb_pixel_reorder_buffer.sv
// Testbench for pixel_reorder_buffer on a small 16x4 frame.
// Raster-order reference model held as a map of pending pixels.
module tb_pixel_reorder_buffer;
  import pixel_pkg::*;

  localparam int NE    = 4;
  localparam int CW    = 11;
  localparam int KW    = 24;
  localparam int IMG_W = 16;
  localparam int IMG_H = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = IMG_W * IMG_H;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NE-1:0]       in_valid = '0;
  logic [NE-1:0]       in_ready;
  logic [NE*CW-1:0]    in_x = '0;
  logic [NE*CW-1:0]    in_y = '0;
  logic [NE*KW-1:0]    in_colour = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [CW-1:0]       out_x;
  logic [CW-1:0]       out_y;
  logic [KW-1:0]       out_colour;
  logic                out_sof;
  logic                out_eol;
  logic [4:0]          occupancy;
  logic                err_dup;
  logic                err_range;

  pixel_reorder_buffer #(
    .NUM_ENGINES(NE),
    .COORD_W    (CW),
    .COLOUR_W   (KW),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_colour (in_colour),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_colour(out_colour),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .occupancy (occupancy),
    .err_dup   (err_dup),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  pixel_t      q [NE][$];
  logic [KW-1:0] mem [int];
  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int m_exp = 0;
  bit exp_dup = 0;
  bit exp_rng = 0;
  int dup_pulses, rng_pulses, occ_max, first_out;
  int sof_seen, sof_wrap, eol_last;
  int out_log [$];
  int acc_edge [NE];
  int gap_pct = 0;
  int rdy_mode = 0;

  function automatic pixel_t mkpix(input int l);
    pixel_t p;
    p.x      = CW'((l % FRAME) % IMG_W);
    p.y      = CW'((l % FRAME) / IMG_W);
    p.colour = KW'($urandom);
    return p;
  endfunction

  function automatic bit busy();
    bit b = (mem.size() > 0);
    for (int e = 0; e < NE; e++)
      if (q[e].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drive();
    for (int e = 0; e < NE; e++) begin
      if (q[e].size() > 0 && $urandom_range(99) >= gap_pct) begin
        in_valid[e]            = 1'b1;
        in_x[e*CW +: CW]       = q[e][0].x;
        in_y[e*CW +: CW]       = q[e][0].y;
        in_colour[e*KW +: KW]  = q[e][0].colour;
      end else begin
        in_valid[e] = 1'b0;
      end
    end
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic step();
    logic [NE-1:0] acc;
    int hx, hy, l;
    pixel_t px;
    @(negedge clk);
    ncmp++;
    if ($countones(in_ready) > 1) begin
      nfail++;
      $display("FAIL ready_onehot got %b want at most one bit", in_ready);
    end
    ncmp++;
    if (err_dup !== exp_dup) begin
      nfail++;
      $display("FAIL err_dup got %b want %b cyc %0d", err_dup, exp_dup, cyc);
    end
    ncmp++;
    if (err_range !== exp_rng) begin
      nfail++;
      $display("FAIL err_range got %b want %b cyc %0d", err_range, exp_rng, cyc);
    end
    if (err_dup === 1'b1) dup_pulses++;
    if (err_range === 1'b1) rng_pulses++;
    if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
    if (out_valid === 1'b1) begin
      hx = m_exp % IMG_W;
      hy = m_exp / IMG_W;
      if (first_out < 0) first_out = cyc;
      ncmp++;
      if (!mem.exists(m_exp)) begin
        nfail++;
        $display("FAIL out_unexpected got (%0d,%0d) want nothing (idx %0d not received)",
                 out_x, out_y, m_exp);
      end else if (out_x !== CW'(hx) || out_y !== CW'(hy) ||
                   out_colour !== mem[m_exp] ||
                   out_sof !== (m_exp == 0) || out_eol !== (hx == IMG_W - 1)) begin
        nfail++;
        $display("FAIL out_pixel got (%0d,%0d,%h,sof%b,eol%b) want (%0d,%0d,%h,sof%b,eol%b)",
                 out_x, out_y, out_colour, out_sof, out_eol,
                 hx, hy, mem[m_exp], m_exp == 0, hx == IMG_W - 1);
      end
      if (out_ready === 1'b1) begin
        out_log.push_back(cyc);
        if (out_sof === 1'b1) sof_seen++;
        if (m_exp == 0 && out_sof === 1'b1) sof_wrap++;
        if (m_exp == FRAME - 1 && out_eol === 1'b1) eol_last++;
        mem.delete(m_exp);
        m_exp = (m_exp + 1) % FRAME;
      end
    end
    exp_dup = 0;
    exp_rng = 0;
    acc = in_valid & in_ready;
    for (int e = 0; e < NE; e++) begin
      if (acc[e]) begin
        px = q[e][0];
        acc_edge[e] = cyc + 1;
        if (int'(px.x) >= IMG_W || int'(px.y) >= IMG_H) begin
          exp_rng = 1;
        end else begin
          l = int'(px.y) * IMG_W + int'(px.x);
          if (mem.exists(l)) exp_dup = 1;
          else mem[l] = px.colour;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int e = 0; e < NE; e++)
      if (acc[e]) void'(q[e].pop_front());
    drive();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((busy() || out_valid === 1'b1) && n < max) begin
      step();
      n++;
    end
    ncmp++;
    if (n >= max) begin
      nfail++;
      $display("FAIL drain_timeout got %0d cycles want < %0d", n, max);
    end
  endtask

  task automatic wait_q(input int e);
    int n = 0;
    while (q[e].size() > 0 && n < 20) begin
      step();
      n++;
    end
    ncmp++;
    if (n >= 20) begin
      nfail++;
      $display("FAIL accept_timeout engine %0d got no accept want accept", e);
    end
  endtask

  task automatic fill_range(input int lo, input int hi);
    for (int l = lo; l <= hi; l++)
      q[$urandom_range(NE - 1)].push_back(mkpix(l));
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ncmp += 6;
    if (in_ready !== '0) begin
      nfail++; $display("FAIL rst_in_ready got %b want 0", in_ready);
    end
    if (out_valid !== 1'b0) begin
      nfail++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    if (occupancy !== '0) begin
      nfail++; $display("FAIL rst_occupancy got %0d want 0", occupancy);
    end
    if (err_dup !== 1'b0 || err_range !== 1'b0) begin
      nfail++; $display("FAIL rst_err got %b%b want 00", err_dup, err_range);
    end
    if (out_sof !== 1'b0 || out_eol !== 1'b0) begin
      nfail++; $display("FAIL rst_flags got %b%b want 00", out_sof, out_eol);
    end
    if (out_x !== '0 || out_y !== '0 || out_colour !== '0) begin
      nfail++; $display("FAIL rst_data got (%0d,%0d,%h) want 0", out_x, out_y, out_colour);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = '0;
  endtask

  task automatic test_in_order();
    int fa;
    gap_pct  = 0;
    rdy_mode = 0;
    sof_seen = 0;
    out_log.delete();
    for (int l = 0; l < 8; l++) q[0].push_back(mkpix(l));
    drive();
    first_out = -1;
    step();
    fa = acc_edge[0];
    drain(100);
    ncmp++;
    if (first_out != fa + 1) begin
      nfail++; $display("FAIL inord_latency got %0d want %0d", first_out, fa + 1);
    end
    ncmp++;
    if (out_log.size() != 8 || out_log[7] - out_log[0] != 7) begin
      nfail++; $display("FAIL inord_throughput got %0d outs want 8 consecutive", out_log.size());
    end
    ncmp++;
    if (sof_seen != 1) begin
      nfail++; $display("FAIL inord_sof got %0d want 1", sof_seen);
    end
  endtask

  task automatic test_out_of_order();
    int base = m_exp;
    int offs[4] = '{3, 1, 2, 0};
    occ_max = 0;
    out_log.delete();
    for (int k = 0; k < 4; k++) begin
      q[k].push_back(mkpix(base + offs[k]));
      drive();
      step();
      ncmp++;
      if (q[k].size() != 0) begin
        nfail++; $display("FAIL ooo_accept engine %0d got stalled want accept", k);
      end
      if (k < 3) begin
        ncmp++;
        if (out_valid !== 1'b0) begin
          nfail++; $display("FAIL ooo_early got %b want 0", out_valid);
        end
      end
    end
    drain(100);
    ncmp++;
    if (out_log.size() != 4 || out_log[3] - out_log[0] != 3) begin
      nfail++; $display("FAIL ooo_burst got %0d outs want 4 consecutive", out_log.size());
    end
    ncmp++;
    if (occ_max != 4) begin
      nfail++; $display("FAIL ooo_occ_peak got %0d want 4", occ_max);
    end
  endtask

  task automatic test_window_stall();
    int base = m_exp;
    int n = 0;
    q[1].push_back(mkpix(base + DEPTH));
    drive();
    for (int k = 0; k < 3; k++) begin
      ncmp++;
      if (in_ready[1] !== 1'b0) begin
        nfail++; $display("FAIL stall_ready got %b want 0", in_ready[1]);
      end
      step();
    end
    q[0].push_back(mkpix(base));
    drive();
    while (q[1].size() > 0 && n < 10) begin
      step();
      n++;
    end
    ncmp++;
    if (acc_edge[1] != acc_edge[0] + 2) begin
      nfail++; $display("FAIL stall_release got edge %0d want %0d",
                        acc_edge[1], acc_edge[0] + 2);
    end
    fill_range(base + 1, base + DEPTH - 1);
    drain(200);
  endtask

  task automatic test_backpressure();
    int base = m_exp;
    int n = 0;
    rdy_mode = 2;
    for (int l = 0; l < 4; l++) q[0].push_back(mkpix(base + l));
    drive();
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      ncmp++;
      if (out_valid !== 1'b1) begin
        nfail++; $display("FAIL bp_hold got %b want 1", out_valid);
      end
    end
    ncmp++;
    if (occupancy !== 5'd3) begin
      nfail++; $display("FAIL bp_occ got %0d want 3", occupancy);
    end
    rdy_mode = 0;
    drain(100);
  endtask

  task automatic test_errors();
    int base = m_exp;
    pixel_t p;
    dup_pulses = 0;
    rng_pulses = 0;
    q[0].push_back(mkpix(base + 5));
    drive();
    wait_q(0);
    q[2].push_back(mkpix(base + 5));
    drive();
    wait_q(2);
    step();
    ncmp++;
    if (dup_pulses != 1) begin
      nfail++; $display("FAIL dup_pulses got %0d want 1", dup_pulses);
    end
    p = mkpix(0);
    p.x = CW'(IMG_W);
    q[3].push_back(p);
    drive();
    wait_q(3);
    p = mkpix(0);
    p.y = CW'(IMG_H);
    q[1].push_back(p);
    drive();
    wait_q(1);
    step();
    ncmp++;
    if (rng_pulses != 2) begin
      nfail++; $display("FAIL range_pulses got %0d want 2", rng_pulses);
    end
    fill_range(base, base + 4);
    drain(200);
  endtask

  task automatic test_random();
    gap_pct  = 30;
    rdy_mode = 1;
    fill_range(m_exp, m_exp + 47);
    drain(3000);
    gap_pct  = 0;
    rdy_mode = 0;
  endtask

  task automatic test_frame_wrap();
    int base = m_exp;
    int want_sof = (base == 0) ? 2 : 1;
    sof_wrap = 0;
    eol_last = 0;
    for (int l = base; l < FRAME; l++) q[0].push_back(mkpix(l));
    q[0].push_back(mkpix(0));
    drive();
    drain(300);
    ncmp++;
    if (eol_last != 1) begin
      nfail++; $display("FAIL wrap_eol got %0d want 1", eol_last);
    end
    ncmp++;
    if (sof_wrap != want_sof) begin
      nfail++; $display("FAIL wrap_sof got %0d want %0d", sof_wrap, want_sof);
    end
  endtask

  task automatic test_reset_midframe();
    int base = m_exp;
    int n = 0;
    for (int k = 1; k <= 6; k++) q[k % NE].push_back(mkpix(base + k));
    drive();
    while (busy_q() && n < 30) begin
      step();
      n++;
    end
    step();
    ncmp++;
    if (occupancy !== 5'd6 || out_valid !== 1'b0) begin
      nfail++; $display("FAIL mid_occ got %0d/%b want 6/0", occupancy, out_valid);
    end
    reset    = 1'b1;
    in_valid = '0;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    ncmp++;
    if (occupancy !== '0 || out_valid !== 1'b0) begin
      nfail++; $display("FAIL mid_reset got %0d/%b want 0/0", occupancy, out_valid);
    end
    mem.delete();
    m_exp   = 0;
    exp_dup = 0;
    exp_rng = 0;
    sof_seen = 0;
    q[0].push_back(mkpix(0));
    q[0].push_back(mkpix(1));
    drive();
    drain(50);
    ncmp++;
    if (sof_seen != 1) begin
      nfail++; $display("FAIL mid_restart_sof got %0d want 1", sof_seen);
    end
  endtask

  function automatic bit busy_q();
    bit b = 0;
    for (int e = 0; e < NE; e++)
      if (q[e].size() > 0) b = 1;
    return b;
  endfunction

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_window_stall();
    test_backpressure();
    test_errors();
    test_random();
    test_frame_wrap();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
